nes_pad_responder: RTL

Controller-side end of the NES serial pad protocol. It emulates the 4021 shift register in a standard pad. It takes latch and pulse (shift clock) from a console or host, snapshots 8 button levels, and returns them bit-serially on the data line in the order A, B, Select, Start, Up, Down, Left, Right. It sits between the FPGA board's button/switch sources and an external host pin or loopback, and lets the host-side controller reader and ButtonCheck be exercised without a physical pad.

---
 rtl/nes_pad_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/nes_pad_responder.sv
// Controller-side NES pad emulation: a 4021-style parallel-in/serial-out responder.
// Snapshots 8 buttons on latch and shifts them out on each host pulse rise (A first).
module nes_pad_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ACTIVE_LOW     = 1,
    parameter int FILL_BIT       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       latch_in,
    input  logic       pulse_in,
    input  logic [7:0] buttons,
    output logic       data_out,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] bits_sent
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    localparam int   TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic POL  = 1'(ACTIVE_LOW);
    localparam logic FILL = 1'(FILL_BIT);

    state_t                 state, next_state;
    logic [SYNC_STAGES-1:0] latch_sync, pulse_sync;
    logic                   latch_hist, pulse_hist;
    logic                   latch_s, pulse_s, latch_rise, pulse_rise;
    logic [7:0]             snapshot;
    logic [TW-1:0]          tcount;
    logic                   timeout_hit;

    assign latch_s     = latch_sync[SYNC_STAGES-1];
    assign pulse_s     = pulse_sync[SYNC_STAGES-1];
    assign latch_rise  = latch_s & ~latch_hist;
    assign pulse_rise  = pulse_s & ~pulse_hist;
    assign timeout_hit = (tcount == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: non-blocking assignments make each flop see its neighbour's old value,
    // which is what turns this chain into a real multi-stage synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_sync <= '0;
            pulse_sync <= '0;
            latch_hist <= 1'b0;
            pulse_hist <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
            pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pulse_in};
            latch_hist <= latch_s;
            pulse_hist <= pulse_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (latch_s) next_state = LOAD;
            LOAD:  if (!latch_s) next_state = SHIFT;
            SHIFT: begin
                if (latch_rise)                              next_state = LOAD;
                else if (pulse_rise && bits_sent == 4'd7)    next_state = IDLE;
                else if (!pulse_rise && timeout_hit)         next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == LOAD) || (state == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot   <= '0;
            bits_sent  <= '0;
            frame_done <= 1'b0;
            data_out   <= FILL;
            tcount     <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    data_out <= FILL;
                    tcount   <= '0;
                    if (latch_s) begin
                        snapshot  <= buttons;
                        data_out  <= buttons[0] ^ POL;
                        bits_sent <= '0;
                    end
                end
                LOAD: begin
                    tcount <= '0;
                    if (latch_s) begin
                        snapshot  <= buttons;
                        data_out  <= buttons[0] ^ POL;
                        bits_sent <= '0;
                    end
                end
                SHIFT: begin
                    // Latch re-assertion outranks a coincident pulse and restarts the frame.
                    if (latch_rise) begin
                        snapshot  <= buttons;
                        data_out  <= buttons[0] ^ POL;
                        bits_sent <= '0;
                        tcount    <= '0;
                    end else if (pulse_rise) begin
                        tcount    <= '0;
                        bits_sent <= bits_sent + 4'd1;
                        snapshot  <= snapshot >> 1;
                        if (bits_sent == 4'd7) begin
                            data_out   <= FILL;
                            frame_done <= 1'b1;
                        end else begin
                            data_out <= snapshot[1] ^ POL;
                        end
                    end else if (timeout_hit) begin
                        data_out <= FILL;
                        tcount   <= '0;
                    end else begin
                        tcount <= tcount + TW'(1);
                    end
                end
                default: data_out <= FILL;
            endcase
        end
    end

endmodule
